// File: rtl/osd_font_pkg.sv
// osd_font_pkg: shared OSD font data and helpers for the text line renderer.
//   Provides glyph geometry defaults, the FONT bitmap constant, the renderer
//   FSM state type and a VideoMode -> (text, invert) mapping for mode strings.
package osd_font_pkg;

  localparam int FONT_GLYPH_W = 8;
  localparam int FONT_GLYPH_H = 16;
  localparam int FONT_CODE_W  = 6;
  localparam int NUM_GLYPHS   = 1 << FONT_CODE_W;
  localparam int LINE_CHARS   = 17;

  typedef logic [NUM_GLYPHS-1:0][FONT_GLYPH_H-1:0][FONT_GLYPH_W-1:0] font_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } render_state_t;

  typedef enum logic [3:0] {
    VM_NONE  = 4'b0000,
    VM_1080P = 4'b1000,
    VM_720P  = 4'b0100,
    VM_1080I = 4'b0010,
    VM_576I  = 4'b0001
  } video_mode_t;

  typedef struct packed {
    logic [LINE_CHARS*FONT_CODE_W-1:0] text;
    logic [LINE_CHARS-1:0]             invert;
  } osd_line_t;

  // Code map: 0 space, 1..10 digits '0'..'9', 11 'x', 12 'i', 13 'p',
  // 14 'H', 15 'z'. Source art is 5x7, top row in the MSBs.
  function automatic logic [34:0] glyph_5x7(input int code);
    case (code)
      1:  return 35'b01110_10001_10011_10101_11001_10001_01110;
      2:  return 35'b00100_01100_00100_00100_00100_00100_01110;
      3:  return 35'b01110_10001_00001_00010_00100_01000_11111;
      4:  return 35'b11110_00001_00001_01110_00001_00001_11110;
      5:  return 35'b00010_00110_01010_10010_11111_00010_00010;
      6:  return 35'b11111_10000_11110_00001_00001_10001_01110;
      7:  return 35'b00110_01000_10000_11110_10001_10001_01110;
      8:  return 35'b11111_00001_00010_00100_01000_01000_01000;
      9:  return 35'b01110_10001_10001_01110_10001_10001_01110;
      10: return 35'b01110_10001_10001_01111_00001_00010_01100;
      11: return 35'b00000_00000_10001_01010_00100_01010_10001;
      12: return 35'b00100_00000_01100_00100_00100_00100_01110;
      13: return 35'b00000_00000_11110_10001_11110_10000_10000;
      14: return 35'b10001_10001_10001_11111_10001_10001_10001;
      15: return 35'b00000_00000_11111_00010_00100_01000_11111;
      default: return 35'b0;
    endcase
  endfunction

  // 5x7 art is doubled vertically into rows 2..15 (rows 0..1 are top
  // spacing) and sits in pixels 1..5 of the 8-pixel cell. Unassigned codes
  // get a code-derived hatch so a bad code is visible rather than blank.
  function automatic font_t build_font();
    font_t       f;
    logic [34:0] g;
    int          sr;
    f = '0;
    for (int c = 0; c < NUM_GLYPHS; c++) begin
      g = glyph_5x7(c);
      for (int r = 0; r < FONT_GLYPH_H; r++) begin
        if (c < 16) begin
          if (r >= 2) begin
            sr = (r - 2) / 2;
            f[c][r] = {1'b0, g[34-5*sr -: 5], 2'b00};
          end
        end else begin
          f[c][r] = 8'(c * 37) ^ 8'(r * 17);
        end
      end
    end
    return f;
  endfunction

  localparam font_t FONT = build_font();

  function automatic logic [FONT_CODE_W-1:0] char_code(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) return FONT_CODE_W'(ch - 8'h30 + 8'd1);
    case (ch)
      "x":     return FONT_CODE_W'(11);
      "i":     return FONT_CODE_W'(12);
      "p":     return FONT_CODE_W'(13);
      "H":     return FONT_CODE_W'(14);
      "z":     return FONT_CODE_W'(15);
      default: return '0;
    endcase
  endfunction

  // Unknown modes show a solid inverted bar so a missing table entry stands out.
  function automatic osd_line_t mode_line(input logic [3:0] mode);
    osd_line_t                 l;
    logic [8*LINE_CHARS-1:0]   s;
    l.invert = '0;
    case (video_mode_t'(mode))
      VM_1080P: s = "1920x1080p 60Hz  ";
      VM_720P:  s = "1280x720p 60Hz   ";
      VM_1080I: s = "1920x1080i 50Hz  ";
      VM_576I:  s = "720x576i 50Hz    ";
      default: begin
        s        = {LINE_CHARS{" "}};
        l.invert = '1;
      end
    endcase
    for (int i = 0; i < LINE_CHARS; i++) begin
      l.text[(LINE_CHARS-1-i)*FONT_CODE_W +: FONT_CODE_W] = char_code(s[(LINE_CHARS-1-i)*8 +: 8]);
    end
    return l;
  endfunction

endpackage

// File: rtl/font_rom.sv
// font_rom: synchronous-read glyph ROM holding osd_font_pkg::FONT.
//   Ports: clock, en (read strobe), addr = {code, glyph row}, data = one glyph
//   row, valid the cycle after en; data holds between reads.
module font_rom
  import osd_font_pkg::*;
(
  input  logic                                          clock,
  input  logic                                          en,
  input  logic [FONT_CODE_W+$clog2(FONT_GLYPH_H)-1:0]   addr,
  output logic [FONT_GLYPH_W-1:0]                       data
);

  localparam int ROW_AW = $clog2(FONT_GLYPH_H);

  always_ff @(posedge clock) begin
    if (en) begin
      data <= FONT[addr[ROW_AW +: FONT_CODE_W]][addr[ROW_AW-1:0]];
    end
  end

endmodule

// File: rtl/text_line_renderer.sv
// text_line_renderer: renders a NUM_CHARS string of glyph codes into one pixel row.
//   Ports: clock/reset_n; start, row, scale_y, text, invert requests a row;
//   busy/done handshake; q holds the last complete row (char 0 pixel 0 in MSB).
module text_line_renderer
  import osd_font_pkg::*;
#(
  parameter int NUM_CHARS = 17,
  parameter int GLYPH_W   = FONT_GLYPH_W,
  parameter int GLYPH_H   = FONT_GLYPH_H,
  parameter int CODE_W    = FONT_CODE_W
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [$clog2(2*GLYPH_H)-1:0]   row,
  input  logic                           scale_y,
  input  logic [NUM_CHARS*CODE_W-1:0]    text,
  input  logic [NUM_CHARS-1:0]           invert,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CHARS*GLYPH_W-1:0]   q
);

  localparam int ROW_W  = $clog2(2*GLYPH_H);
  localparam int GROW_W = $clog2(GLYPH_H);
  localparam int K_W    = $clog2(NUM_CHARS+1);

  render_state_t               state;
  render_state_t               state_nxt;
  logic [K_W-1:0]              k;
  logic [NUM_CHARS*CODE_W-1:0] text_l;
  logic [NUM_CHARS-1:0]        inv_l;
  logic [GROW_W-1:0]           grow_l;
  logic                        blank_l;
  logic [ROW_W-1:0]            grow_in;
  logic [NUM_CHARS*GLYPH_W-1:0] line_buf;
  logic [NUM_CHARS*GLYPH_W-1:0] line_nxt;

  logic                        accept;
  logic                        issue;
  logic                        capture;
  logic                        last;
  logic [CODE_W-1:0]           code_sel;
  logic                        inv_sel;
  logic [GLYPH_W-1:0]          rom_data;
  logic [GLYPH_W-1:0]          cap_pix;

  assign grow_in = scale_y ? (row >> 1) : row;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the last RUN edge is the one that also captures char NUM_CHARS-1
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (k == K_W'(NUM_CHARS)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs / control strobes. Reads run one cycle ahead of captures because
  // the ROM is registered: read char k while capturing char k-1.
  always_comb begin
    accept  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    case (state)
      S_IDLE: accept = start;
      S_RUN: begin
        busy    = 1'b1;
        issue   = (k < K_W'(NUM_CHARS));
        capture = (k != '0);
        last    = (k == K_W'(NUM_CHARS));
      end
      default: ;
    endcase
  end

  // Read-side code mux (char k) and capture-side merge (char k-1).
  always_comb begin
    code_sel = '0;
    inv_sel  = 1'b0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (k == K_W'(i))   code_sel = text_l[(NUM_CHARS-1-i)*CODE_W +: CODE_W];
      if (k == K_W'(i+1)) inv_sel  = inv_l[NUM_CHARS-1-i];
    end
    // Rows past the glyph height are blank, but inverse video still applies.
    cap_pix  = (blank_l ? '0 : rom_data) ^ {GLYPH_W{inv_sel}};
    line_nxt = line_buf;
    if (capture) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (k == K_W'(i+1)) line_nxt[(NUM_CHARS-1-i)*GLYPH_W +: GLYPH_W] = cap_pix;
      end
    end
  end

  font_rom u_font_rom (
    .clock (clock),
    .en    (issue),
    .addr  ({code_sel, grow_l}),
    .data  (rom_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k        <= '0;
      text_l   <= '0;
      inv_l    <= '0;
      grow_l   <= '0;
      blank_l  <= 1'b0;
      line_buf <= '0;
      q        <= '0;
      done     <= 1'b0;
    end else begin
      done     <= last;
      line_buf <= line_nxt;
      if (accept) begin
        text_l  <= text;
        inv_l   <= invert;
        grow_l  <= grow_in[GROW_W-1:0];
        blank_l <= (grow_in >= ROW_W'(GLYPH_H));
        k       <= '0;
      end else if (issue) begin
        k <= k + K_W'(1);
      end
      // line_nxt already carries the final capture, so q updates in one step.
      if (last) q <= line_nxt;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// tb_text_line_renderer: randomized and directed bench for text_line_renderer.
//   Expected rows come from a per-character reference model over the font table,
//   plus hand-derived constants for known glyph rows.
module tb_text_line_renderer;
  import osd_font_pkg::*;

  localparam int NC = 17;
  localparam int TW = NC * 6;
  localparam int QW = NC * 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [4:0]    row;
  logic          scale_y;
  logic [TW-1:0] text;
  logic [NC-1:0] invert;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;

  int n_chk  = 0;
  int n_pass = 0;

  text_line_renderer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .row     (row),
    .scale_y (scale_y),
    .text    (text),
    .invert  (invert),
    .busy    (busy),
    .done    (done),
    .q       (q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: each char independently looks up its glyph row, blank past
  // the glyph height, then optionally inverted.
  function automatic logic [QW-1:0] model(input logic [TW-1:0] txt, input logic [NC-1:0] inv,
                                          input logic [4:0] r, input logic sc);
    logic [QW-1:0] m;
    logic [7:0]    pix;
    logic [5:0]    code;
    int            g;
    m = '0;
    g = sc ? int'(r) / 2 : int'(r);
    for (int i = 0; i < NC; i++) begin
      code = txt[(NC-1-i)*6 +: 6];
      pix  = (g < 16) ? FONT[code][g] : 8'h00;
      if (inv[NC-1-i]) pix = ~pix;
      m[(NC-1-i)*8 +: 8] = pix;
    end
    return m;
  endfunction

  function automatic logic [TW-1:0] rand_text();
    logic [TW-1:0] t;
    for (int i = 0; i < NC; i++) t[i*6 +: 6] = 6'($urandom_range(0, 63));
    return t;
  endfunction

  task automatic do_render(input logic [TW-1:0] txt, input logic [NC-1:0] inv, input logic [4:0] r,
                           input logic sc, input bit scramble,
                           output logic [QW-1:0] got, output int lat, output int bcnt);
    @(posedge clock); #1;
    text = txt; invert = inv; row = r; scale_y = sc; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (scramble) begin
        text = rand_text(); invert = NC'($urandom); row = 5'($urandom); scale_y = 1'($urandom);
      end
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
    end
    got = q;
  endtask

  logic [QW-1:0] got, got2, q1, q2;
  logic [TW-1:0] t1, t2;
  logic [NC-1:0] iv;
  logic [4:0]    rr;
  logic          ss;
  int            lat, bcnt;
  int            acc_cnt, done_cnt, acc_e[2], done_e[2];
  logic          prev_busy;
  osd_line_t     ml;

  initial begin
    reset_n = 1'b0; start = 1'b0; row = '0; scale_y = 1'b0; text = '0; invert = '0;
    #12;
    chk("rst_busy", QW'(busy), '0);
    chk("rst_done", QW'(done), '0);
    chk("rst_q", q, '0);
    #5 reset_n = 1'b1;

    // Basic: all '0', row 2
    t1 = {NC{6'd1}};
    do_render(t1, '0, 5'd2, 1'b0, 1'b0, got, lat, bcnt);
    chk("basic_lat", QW'(lat), QW'(18));
    chk("basic_busy_cycles", QW'(bcnt), QW'(18));
    chk("basic_q", got, {NC{8'h38}});
    chk("basic_done_busy_low", QW'(busy), '0);
    @(posedge clock); #1;
    chk("basic_done_pulse", QW'(done), '0);

    // Invert on blank: char 0 solid, rest 0
    do_render('0, 17'h10000, 5'd5, 1'b0, 1'b0, got, lat, bcnt);
    chk("inv_blank_q", got, {8'hFF, 128'h0});

    // Scaling equivalence and out-of-range row
    t1 = rand_text(); iv = NC'($urandom);
    do_render(t1, iv, 5'd9, 1'b1, 1'b0, got, lat, bcnt);
    chk("scale_y1_r9", got, model(t1, iv, 5'd4, 1'b0));
    do_render(t1, iv, 5'd4, 1'b0, 1'b0, got2, lat, bcnt);
    chk("scale_y0_r4", got2, model(t1, iv, 5'd9, 1'b1));
    do_render(t1, '0, 5'd20, 1'b0, 1'b0, got, lat, bcnt);
    chk("oor_r20_q", got, '0);
    chk("oor_r20_lat", QW'(lat), QW'(18));
    do_render(t1, '1, 5'd16, 1'b0, 1'b0, got, lat, bcnt);
    chk("oor_r16_inv", got, {QW{1'b1}});

    // Reset mid-run, after a nonzero q exists
    do_render({NC{6'd9}}, '0, 5'd3, 1'b0, 1'b0, got, lat, bcnt);
    chk("pre_reset_q", got, model({NC{6'd9}}, '0, 5'd3, 1'b0));
    @(posedge clock); #1;
    text = {NC{6'd2}}; invert = '0; row = 5'd6; scale_y = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", QW'(busy), '0);
    chk("midrun_rst_done", QW'(done), '0);
    chk("midrun_rst_q", q, '0);
    #3 reset_n = 1'b1;
    t1 = {NC{6'd1}};
    do_render(t1, '0, 5'd2, 1'b0, 1'b0, got, lat, bcnt);
    chk("post_rst_q", got, {NC{8'h38}});
    chk("post_rst_lat", QW'(lat), QW'(18));

    // Handshake: start held for 38 edges -> two accepts, text change at T+3
    t1 = rand_text(); t2 = rand_text();
    @(posedge clock); #1;
    text = t1; invert = '0; row = 5'd7; scale_y = 1'b0; start = 1'b1;
    acc_cnt = 0; done_cnt = 0; prev_busy = 1'b0; q1 = '0; q2 = '0;
    acc_e[0] = -1; acc_e[1] = -1; done_e[0] = -1; done_e[1] = -1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clock); #1;
      if (e == 3) text = t2;
      if (e == 37) start = 1'b0;
      if (busy && !prev_busy) begin
        if (acc_cnt < 2) acc_e[acc_cnt] = e;
        acc_cnt++;
      end
      prev_busy = busy;
      if (done) begin
        if (done_cnt == 0) q1 = q;
        if (done_cnt == 1) q2 = q;
        if (done_cnt < 2) done_e[done_cnt] = e;
        done_cnt++;
      end
    end
    chk("hs_accepts", QW'(acc_cnt), QW'(2));
    chk("hs_dones", QW'(done_cnt), QW'(2));
    chk("hs_acc0_edge", QW'(acc_e[0]), QW'(0));
    chk("hs_acc1_edge", QW'(acc_e[1]), QW'(19));
    chk("hs_done0_edge", QW'(done_e[0]), QW'(18));
    chk("hs_done1_edge", QW'(done_e[1]), QW'(37));
    chk("hs_q1", q1, model(t1, '0, 5'd7, 1'b0));
    chk("hs_q2", q2, model(t2, '0, 5'd7, 1'b0));

    // Mode strings from the package, rows 0..15
    for (int m = 0; m < 2; m++) begin
      ml = mode_line(m == 0 ? 4'b1000 : 4'b0100);
      for (int r = 0; r < 16; r++) begin
        do_render(ml.text, ml.invert, 5'(r), 1'b0, 1'b0, got, lat, bcnt);
        chk($sformatf("mode%0d_row%0d", m, r), got, model(ml.text, ml.invert, 5'(r), 1'b0));
        if (m == 0 && r == 2) chk("mode1080_c0_r2", QW'(got[QW-1 -: 8]), QW'(8'h10));
      end
    end

    // Random rows with inputs scrambled while busy
    for (int n = 0; n < 24; n++) begin
      t1 = rand_text(); iv = NC'($urandom); rr = 5'($urandom); ss = 1'($urandom);
      do_render(t1, iv, rr, ss, 1'b1, got, lat, bcnt);
      chk($sformatf("rand%0d_lat", n), QW'(lat), QW'(18));
      chk($sformatf("rand%0d_q", n), got, model(t1, iv, rr, ss));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
